fakeram130_64x96_req_ctrl: RTL and testbench

//   Request-side controller placed directly upstream of the 64x96 single-port SRAM macro.
//   - Accepts read/write requests on a valid/ready interface and drives the macro pins.
//   - Captures macro read data into a small output FIFO, consumed on a valid/yumi interface.
//   - Read credits are counted so read data is never dropped under backpressure.

---
 rtl/fakeram130_req_ctrl_pkg.sv | 21 ++
 rtl/fakeram130_rd_fifo.sv | 59 +++++
 rtl/fakeram130_64x96_req_ctrl.sv | 137 +++++++++++++
 tb/tb_fakeram130_64x96_req_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fakeram130_req_ctrl_pkg.sv
// Shared definitions for the fakeram130 64x96 request-side controller.
//   - Default geometry (WIDTH, DEPTH, FIFO_ELS) matching the SRAM macro.
//   - ctrl_state_e: controller state, INIT (optional clearing sweep) and RUN.
//   - req_s: one request as seen on the upstream valid/ready interface.
package fakeram130_req_ctrl_pkg;

  localparam int unsigned DefaultWidth     = 96;
  localparam int unsigned DefaultDepth     = 64;
  localparam int unsigned DefaultAddrWidth = $clog2(DefaultDepth);
  localparam int unsigned DefaultFifoEls   = 2;

  typedef enum logic {INIT, RUN} ctrl_state_e;

  typedef struct packed {
    logic                        w;
    logic [DefaultAddrWidth-1:0] addr;
    logic [DefaultWidth-1:0]     data;
    logic [DefaultWidth-1:0]     mask;
  } req_s;

endpackage

// File: rtl/fakeram130_rd_fifo.sv
// Read-data FIFO for the fakeram130 request controller.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i   write one entry (caller guarantees space)
//   pop_i            remove the head; ignored while empty
//   data_o, v_o      head entry and its valid
//   count_o          number of stored entries
// Push and pop in the same cycle are allowed, including while full.
module fakeram130_rd_fifo
  import fakeram130_req_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned ELS   = DefaultFifoEls  // at least 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       v_o,
  output logic [$clog2(ELS+1)-1:0]   count_o
);

  localparam int unsigned CntW = $clog2(ELS + 1);
  localparam int unsigned PtrW = $clog2(ELS);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(ELS - 1);

  logic [WIDTH-1:0] mem_q [ELS];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap explicitly so ELS need not be a power of two.
      if (push_i) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (push_i && !do_pop)      count_q <= count_q + 1'b1;
      else if (!push_i && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // Storage is not reset; count_q alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !reset_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fakeram130_64x96_req_ctrl.sv
// Request-side controller in front of the fakeram130 64x96 single-port SRAM macro.
// Ports:
//   clk_i, reset_i                 clock (shared with the macro), sync active-high reset
//   v_i, w_i, addr_i, data_i,      request valid/ready interface; mask_i 1 = bit written
//   mask_i, ready_o
//   data_o, v_o, yumi_i            read data FIFO head, valid, consumer pop
//   init_done_o                    out of INIT and accepting requests
//   sram_ce_o .. sram_wmask_o      macro pins, driven combinationally for an accepted request
//   sram_rd_i                      macro read data, valid the cycle after a read issues
// Optional feature: define SRAM_CTRL_INIT_EN to sweep zeros into every word after reset
// before accepting requests. Without it the block enters RUN straight out of reset.
module fakeram130_64x96_req_ctrl
  import fakeram130_req_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter int unsigned DEPTH      = DefaultDepth,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned FIFO_ELS   = DefaultFifoEls
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  v_i,
  input  logic                  w_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic [WIDTH-1:0]      mask_i,
  output logic                  ready_o,
  output logic [WIDTH-1:0]      data_o,
  output logic                  v_o,
  input  logic                  yumi_i,
  output logic                  init_done_o,
  output logic                  sram_ce_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [WIDTH-1:0]      sram_wd_o,
  output logic [WIDTH-1:0]      sram_wmask_o,
  input  logic [WIDTH-1:0]      sram_rd_i
);

  localparam int unsigned CntW = $clog2(FIFO_ELS + 1);

  ctrl_state_e           state_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic                  sweeping;
  logic                  init_done;
  logic                  pop;
  logic                  accept;
  logic                  accept_rd;
  logic [CntW:0]         occupancy;
  logic [CntW-1:0]       fifo_count;
  logic                  fifo_v;
  logic [WIDTH-1:0]      fifo_data;

  // State register. During reset every visible output is forced low below, so the
  // reset value of state_q only matters once reset_i drops.
`ifdef SRAM_CTRL_INIT_EN
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  logic [ADDR_WIDTH-1:0] sweep_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else if (state_q == INIT) begin
      sweep_q <= sweep_q + 1'b1;
      if (sweep_q == LastAddr) state_q <= RUN;
    end
  end

  assign sweep_addr = sweep_q;
  assign sweeping   = (state_q == INIT) & ~reset_i;
`else
  always_ff @(posedge clk_i) begin
    state_q <= RUN;
  end

  assign sweep_addr = '0;
  assign sweeping   = 1'b0;
`endif

  assign init_done   = (state_q == RUN) & ~reset_i;
  assign init_done_o = init_done;

  assign v_o    = fifo_v & ~reset_i;
  assign data_o = reset_i ? '0 : fifo_data;
  assign pop    = v_o & yumi_i;

  // Reads accepted but not yet popped: stored entries plus the one in the macro pipe.
  // Counting the pop this cycle (combinational yumi_i -> ready_o) sustains one read per
  // cycle with a two-entry FIFO. Writes are gated by the same rule.
  assign occupancy = {1'b0, fifo_count} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
  assign ready_o   = init_done & (occupancy < (CntW + 1)'(FIFO_ELS));
  assign accept    = v_i & ready_o;
  assign accept_rd = accept & ~w_i;

  always_comb begin
    sram_ce_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wd_o    = '0;
    sram_wmask_o = '0;
    if (sweeping) begin
      sram_ce_o    = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = sweep_addr;
      sram_wmask_o = '1;
    end else if (accept) begin
      sram_ce_o    = 1'b1;
      sram_we_o    = w_i;
      sram_addr_o  = addr_i;
      sram_wd_o    = data_i;
      sram_wmask_o = mask_i;
    end
  end

  // Macro data appears one cycle after the read; capture it then.
  always_ff @(posedge clk_i) begin
    if (reset_i) inflight_q <= 1'b0;
    else         inflight_q <= accept_rd;
  end

  fakeram130_rd_fifo #(
    .WIDTH (WIDTH),
    .ELS   (FIFO_ELS)
  ) u_rd_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (inflight_q),
    .data_i  (sram_rd_i),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .v_o     (fifo_v),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_fakeram130_64x96_req_ctrl.sv
// Self-checking bench for fakeram130_64x96_req_ctrl. A behavioural SRAM macro drives
// sram_rd_i; a transaction-level reference (memory image + queue of pending reads)
// predicts every output each cycle. Works with or without SRAM_CTRL_INIT_EN.
module tb_fakeram130_64x96_req_ctrl;

  localparam int W   = 96;
  localparam int D   = 64;
  localparam int AW  = 6;
  localparam int ELS = 2;
`ifdef SRAM_CTRL_INIT_EN
  localparam int SweepStart = 0;
`else
  localparam int SweepStart = D;
`endif
  localparam logic [W-1:0] A5 = 96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          v_i = 1'b0;
  logic          w_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [W-1:0]  data_i = '0;
  logic [W-1:0]  mask_i = '0;
  logic          yumi_i = 1'b0;
  logic          ready_o, v_o, init_done_o, sram_ce_o, sram_we_o;
  logic [W-1:0]  data_o, sram_wd_o, sram_wmask_o;
  logic [W-1:0]  sram_rd_i = '0;
  logic [AW-1:0] sram_addr_o;

  fakeram130_64x96_req_ctrl dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .w_i          (w_i),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .mask_i       (mask_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .v_o          (v_o),
    .yumi_i       (yumi_i),
    .init_done_o  (init_done_o),
    .sram_ce_o    (sram_ce_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wd_o    (sram_wd_o),
    .sram_wmask_o (sram_wmask_o),
    .sram_rd_i    (sram_rd_i)
  );

  always #5 clk = ~clk;

  // Behavioural macro: bit-masked writes, 1-cycle read latency, rd_out holds otherwise.
  logic [W-1:0] sram_mem [D];
  always @(posedge clk) begin
    if (sram_ce_o) begin
      if (sram_we_o)
        sram_mem[sram_addr_o] <= (sram_mem[sram_addr_o] & ~sram_wmask_o)
                                 | (sram_wd_o & sram_wmask_o);
      else
        sram_rd_i <= sram_mem[sram_addr_o];
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pops = 0;
  bit run_checks = 0;
  bit m_accepted = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what memory should hold and which reads are owed to the consumer.
  typedef struct {
    logic [W-1:0] data;
    bit           known;
    int           due;
  } rd_t;

  logic [W-1:0] ref_mem [D];
  bit           ref_known [D];
  rd_t          rd_q [$];
  int           sweep_cnt = SweepStart;

  bit            e_init_done, e_v, e_pop, e_ready, e_accept, e_sweep, e_ce, e_we;
  logic [AW-1:0] e_addr;
  logic [W-1:0]  e_wd, e_mask;

  task automatic eval_model();
    e_init_done = !reset_i && (sweep_cnt >= D);
    e_sweep     = !reset_i && (sweep_cnt < D);
    e_v         = !reset_i && (rd_q.size() > 0) && (rd_q[0].due <= cyc);
    e_pop       = e_v && yumi_i;
    // Reads owed (accepted, not yet popped) may never exceed the FIFO size.
    e_ready     = e_init_done && ((rd_q.size() - (e_pop ? 1 : 0)) < ELS);
    e_accept    = v_i && e_ready;
    e_ce = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_mask = '0;
    if (e_sweep) begin
      e_ce = 1'b1; e_we = 1'b1; e_addr = AW'(sweep_cnt); e_mask = '1;
    end else if (e_accept) begin
      e_ce = 1'b1; e_we = w_i; e_addr = addr_i; e_wd = data_i; e_mask = mask_i;
    end
  endtask

  always @(posedge clk) begin
    rd_t e;
    eval_model();
    m_accepted = 1'b0;
    if (reset_i) begin
      rd_q.delete();
      sweep_cnt = SweepStart;
    end else begin
      if (e_pop) begin
        void'(rd_q.pop_front());
        pops++;
      end
      if (e_sweep) begin
        ref_mem[sweep_cnt]   = '0;
        ref_known[sweep_cnt] = 1'b1;
        sweep_cnt++;
      end else if (e_accept) begin
        m_accepted = 1'b1;
        if (w_i) begin
          ref_mem[addr_i]   = (ref_mem[addr_i] & ~mask_i) | (data_i & mask_i);
          ref_known[addr_i] = ref_known[addr_i] || (mask_i == '1);
        end else begin
          e.data  = ref_mem[addr_i];
          e.known = ref_known[addr_i];
          e.due   = cyc + 2;
          rd_q.push_back(e);
        end
      end
    end
    cyc++;
  end

  // Cycle-by-cycle comparison against the reference, sampled mid-cycle.
  always @(negedge clk) begin
    if (run_checks) begin
      eval_model();
      check_bit("ready_o", ready_o, e_ready);
      check_bit("v_o", v_o, e_v);
      check_bit("init_done_o", init_done_o, e_init_done);
      check_bit("sram_ce_o", sram_ce_o, e_ce);
      check_bit("sram_we_o", sram_we_o, e_we);
      if (e_ce || reset_i) begin
        check_w("sram_addr_o", W'(sram_addr_o), W'(e_addr));
        check_w("sram_wd_o", sram_wd_o, e_wd);
        check_w("sram_wmask_o", sram_wmask_o, e_mask);
      end
      if (reset_i) check_w("data_o_reset", data_o, '0);
      else if (e_v && rd_q[0].known) check_w("data_o", data_o, rd_q[0].data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit w, input int a, input logic [W-1:0] d, input logic [W-1:0] m);
    bit done = 1'b0;
    v_i = 1'b1; w_i = w; addr_i = AW'(a); data_i = d; mask_i = m;
    for (int k = 0; k < 200 && !done; k++) begin
      step();
      done = m_accepted;
    end
    v_i = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: got no accept want accept of addr %0d", a);
    end
  endtask

  // Read with an empty pipe: v_o low in N+1, high with lit in N+2 (popped by yumi_i=1).
  task automatic read_expect(input string name, input int a, input logic [W-1:0] lit);
    issue(1'b0, a, '0, '0);
    @(negedge clk);
    check_bit({name, "_v_n1"}, v_o, 1'b0);
    step();
    @(negedge clk);
    check_bit({name, "_v_n2"}, v_o, 1'b1);
    check_w({name, "_data"}, data_o, lit);
    step();
  endtask

  function automatic logic [W-1:0] pat(input int i);
    return {3{32'hC0DE_0000 | 32'(i)}};
  endfunction

  initial begin
    int s, p0, nacc, cnt, rise;
    for (int i = 0; i < D; i++) begin
      sram_mem[i]  = {3{32'hDEAD_0000 | 32'(i)}};
      ref_mem[i]   = '0;
      ref_known[i] = 1'b0;
    end
    step();
    run_checks = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    yumi_i  = 1'b1;

`ifdef SRAM_CTRL_INIT_EN
    // Sweep: 64 write cycles at 0..63, init_done_o in cycle 65 after reset drops.
    cnt = 0; rise = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (!init_done_o && sram_ce_o && sram_we_o) cnt++;
      if (init_done_o && rise == 0) rise = k;
      step();
    end
    check_int("t6_sweep_writes", cnt, 64);
    check_int("t6_init_done_cycle", rise, 65);
    read_expect("t6_rd17", 17, '0);
    read_expect("t6_rd63", 63, '0);
`else
    @(negedge clk);
    check_bit("t0_init_done", init_done_o, 1'b1);
    check_bit("t0_ready", ready_o, 1'b1);
    step();
`endif

    // 1: full write then read.
    issue(1'b1, 5, A5, '1);
    read_expect("t1", 5, A5);

    // 2: masked write over all-ones.
    issue(1'b1, 9, '1, '1);
    issue(1'b1, 9, '0, {48'h0, {48{1'b1}}});
    read_expect("t2", 9, {48'hFFFF_FFFF_FFFF, 48'h0});

    // 3: ten back-to-back reads with the consumer always popping.
    for (int i = 0; i < 10; i++) issue(1'b1, i, pat(i), '1);
    s = cyc;
    p0 = pops;
    for (int i = 0; i < 10; i++) issue(1'b0, i, '0, '0);
    check_int("t3_cycles", cyc - s, 10);
    repeat (4) step();
    check_int("t3_returned", pops - p0, 10);

    // 4: backpressure; only FIFO_ELS reads may be accepted.
    yumi_i = 1'b0;
    nacc = 0;
    v_i = 1'b1; w_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      addr_i = AW'(nacc);
      step();
      if (m_accepted) nacc++;
    end
    @(negedge clk);
    check_int("t4_accepted", nacc, 2);
    check_bit("t4_ready", ready_o, 1'b0);
    check_bit("t4_v", v_o, 1'b1);
    check_w("t4_head", data_o, pat(0));
    step();
    v_i = 1'b0;
    yumi_i = 1'b1;
    p0 = pops;
    repeat (4) step();
    check_int("t4_drained", pops - p0, 2);

    // 5: reset with one read stored and one in the macro pipe.
    yumi_i = 1'b0;
    issue(1'b0, 3, '0, '0);
    issue(1'b0, 4, '0, '0);
    reset_i = 1'b1;
    v_i = 1'b1; w_i = 1'b0; addr_i = AW'(7);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_bit("t5_v", v_o, 1'b0);
      check_bit("t5_ready", ready_o, 1'b0);
      check_bit("t5_ce", sram_ce_o, 1'b0);
      step();
    end
    reset_i = 1'b0;
    v_i = 1'b0;
    yumi_i = 1'b1;
`ifdef SRAM_CTRL_INIT_EN
    read_expect("t5", 5, '0);
`else
    read_expect("t5", 5, pat(5));
`endif
    read_expect("t5b", 9, pat(9) & {W{1'b0}} | ref_mem[9]);

`ifdef SRAM_CTRL_INIT_EN
    // 6: reset part-way through the sweep restarts it at address 0.
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    repeat (30) step();
    @(negedge clk);
    check_w("t6_addr30", W'(sram_addr_o), W'(30));
    step();
    reset_i = 1'b1;
    @(negedge clk);
    check_bit("t6_reset_ce", sram_ce_o, 1'b0);
    step();
    reset_i = 1'b0;
    @(negedge clk);
    check_bit("t6_restart_ce", sram_ce_o, 1'b1);
    check_w("t6_restart_addr", W'(sram_addr_o), '0);
    step();
    read_expect("t6_rd40", 40, '0);
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog");
  end

endmodule
